reg_bank8_scan: RTL and testbench
=================================

// Module: reg_bank8_scan
// PURPOSE
//   8-entry x 16-bit register bank with a select sequencer; directly upstream of the 8-way 16-bit mux.
//   Holds the eight data words that drive the mux inputs and generates the mux select.
//   On start, steps the select through every written entry under a valid/ready handshake, skipping unwritten entries.
// PARAMETERS
//   WIDTH   16   bits per entry; all tests use the default
//   DEPTH    8   entry count, fixed at 8 (select is 3 bits)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   wr_en      in   1      write strobe
//   wr_addr    in   3      write index
//   wr_data    in   16     write data
//   clear      in   1      clears all valid bits and aborts any scan
//   start      in   1      start-scan pulse; ignored while busy
//   words      out  128    entry k on [16k+15:16k], registered; drives mux inputs i0..i7
//   sel        out  3      mux select, registered
//   sel_valid  out  1      sel points at a valid entry that has not yet been consumed
//   sel_ready  in   1      consumer accepts the current sel
//   busy       out  1      scan in progress
//   done       out  1      one-cycle pulse at the end of a scan
// BEHAVIOUR
//   Reset: clk is the only clock; rst is asynchronous and active-high.
//     Reset clears all words, the valid bits, sel, sel_valid, busy and done to 0.
//     Reset takes effect at any time, including mid-scan.
//   Write: wr_en at edge t stores wr_data into entry wr_addr and sets its valid bit; words updates at t+1.
//     Writes are allowed at any time.
//   FSM IDLE:
//     start=1 and at least one valid entry -> SCAN.
//       sel = lowest valid index; sel_valid=1 and busy=1 in the next cycle.
//     start=1 with no valid entries -> stays IDLE; done=1 for one cycle in the next cycle; sel_valid stays 0.
//   FSM SCAN:
//     Handshake: sel_valid && sel_ready at an edge consumes sel.
//     After a handshake, sel = next valid index above the current one, in the next cycle; no bubble cycles.
//     Last valid index consumed -> IDLE; sel_valid=0, busy=0 and done=1 in the next cycle; sel holds its last value.
//     sel_ready low -> sel and sel_valid hold.
//   Write during a scan:
//     A write to an index above the current sel is visited in this pass.
//     A write to an index at or below the current sel is not visited until the next start.
//   clear has priority over start and the handshake.
//     Valid bits -> 0; if scanning, go to IDLE with sel_valid=0 and busy=0 and no done pulse.
//     words keep their data.
//   Same-edge write and clear: clear wins; the data is stored but the valid bit stays 0.
//   Index arithmetic is 3-bit. The only wrap past index 7 is in SCAN_WRAP_EN mode.
// CONFIGURATION
//   SCAN_WRAP_EN defined: continuous scan.
//     After the highest valid index, sel wraps to the lowest valid index.
//     done pulses once per completed pass while scanning continues.
//     The scan stops only on clear or rst.
//   SCAN_WRAP_EN undefined: single pass as above.
// TESTING
//   1 Write k -> 16'h0080<<k for k=0..7 (entry 0 = 16'h0080, entry 7 = 16'h4000); start; sel_ready=1
//     -> sel 0..7 on 8 consecutive cycles, then done=1 for one cycle, busy=0.
//   2 Write only entries 2, 5 and 7; start
//     -> sel 2, 5, 7 with sel_valid high, then done.
//     Data reaching the mux is 16'h0200, 16'h1000, 16'h4000.
//   3 Backpressure: hold sel_ready=0 for 3 cycles while sel=5
//     -> sel=5 and sel_valid=1 hold; sel 7 follows one cycle after sel_ready rises.
//   4 Empty bank: start
//     -> done=1 exactly one cycle later; sel_valid never asserts; busy stays 0.
//   5 Assert clear at sel=3, and separately rst at sel=3
//     -> clear: IDLE with no done and words retained.
//     -> rst: all outputs 0 immediately, without waiting for a clock edge.
//   6 SCAN_WRAP_EN with entries 1 and 6 valid
//     -> sel 1, 6, 1, 6 ...; done pulses after each 6 is consumed.

Source files
------------

// File: rtl/reg_bank8_scan.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank8_scan
// Purpose  : 8 x 16-bit register bank feeding an 8-way mux, with a select
//            sequencer that walks every written entry under valid/ready.
// Config   : SCAN_WRAP_EN - when defined, the scan wraps continuously and
//            pulses done once per completed pass; otherwise single pass.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank8_scan #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [2:0]               wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  output logic [DEPTH*WIDTH-1:0]   words_o,
  output logic [2:0]               sel_o,
  output logic                     sel_valid_o,
  input  logic                     sel_ready_i,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   words_q;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [2:0]                    sel_q, sel_d;
  logic                          done_q, done_d;

  logic [DEPTH-1:0]              w_wr_mask;
  logic [DEPTH-1:0]              w_valid_eff;
  logic [DEPTH-1:0]              w_above;
  logic [3:0]                    w_low_all;
  logic [3:0]                    w_low_above;

  // Lowest set bit of a mask as {found, index}.
  function automatic logic [3:0] lowest(input logic [DEPTH-1:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // A same-edge write counts as valid so a freshly written entry is never missed.
  always_comb begin
    w_wr_mask   = wr_en_i ? (DEPTH'(1) << wr_addr_i) : '0;
    w_valid_eff = valid_q | w_wr_mask;
    for (int i = 0; i < DEPTH; i++) begin
      w_above[i] = w_valid_eff[i] && (i > int'(sel_q));
    end
    w_low_all   = lowest(w_valid_eff);
    w_low_above = lowest(w_above);
  end

  // Next-state logic for the sequencer; clear overrides start and handshake.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    valid_d = w_valid_eff;
    if (clear_i) begin
      valid_d = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (w_low_all[3]) begin
              state_d = S_SCAN;
              sel_d   = w_low_all[2:0];
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (sel_ready_i) begin
            if (w_low_above[3]) begin
              sel_d = w_low_above[2:0];
            end else begin
`ifdef SCAN_WRAP_EN
              // Pass complete: restart at the lowest valid entry, keep scanning.
              done_d = 1'b1;
              if (w_low_all[3]) begin
                sel_d = w_low_all[2:0];
              end else begin
                state_d = S_IDLE;
              end
`else
              done_d  = 1'b1;
              state_d = S_IDLE;
`endif
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sequencer state, valid bits and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      sel_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  // Data storage; data is written even when a same-edge clear drops the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
    end else if (wr_en_i) begin
      words_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign words_o     = words_q;
  assign sel_o       = sel_q;
  assign sel_valid_o = (state_q == S_SCAN);
  assign busy_o      = (state_q == S_SCAN);
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank8_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank8_scan
// Purpose  : Directed self-checking bench for reg_bank8_scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank8_scan;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_addr = 3'd0;
  logic [15:0]  wr_data = 16'd0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [127:0] words;
  logic [2:0]   sel;
  logic         sel_valid;
  logic         sel_ready = 1'b0;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  reg_bank8_scan dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .clear_i     (clear),
    .start_i     (start),
    .words_o     (words),
    .sel_o       (sel),
    .sel_valid_o (sel_valid),
    .sel_ready_i (sel_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    checks++; if (words !== 128'd0) begin errors++; $display("FAIL reset_words got %h exp 0", words); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
    checks++; if ({sel_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {sel_valid, busy, done}); end
  endtask

  task automatic test_empty();
    do_clear();
    do_start();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done got %b exp 1", done); end
    checks++; if ({sel_valid, busy} !== 2'b00) begin errors++; $display("FAIL empty_valid_busy got %b exp 00", {sel_valid, busy}); end
    tick();
    checks++; if ({sel_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL empty_after got %b exp 000", {sel_valid, busy, done}); end
  endtask

  task automatic test_clear_mid_scan();
    do_clear();
    for (int k = 0; k < 8; k++) wr(k, 16'h0080 << k);
    sel_ready = 1'b1;
    do_start();
    tick(); tick(); tick();
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL clr_presel got %0d exp 3", sel); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if ({sel_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL clr_flags got %b exp 000", {sel_valid, busy, done}); end
    checks++; if (words[3*16 +: 16] !== 16'h0400) begin errors++; $display("FAIL clr_words got %h exp 0400", words[3*16 +: 16]); end
    tick();
    checks++; if ({sel_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL clr_after got %b exp 000", {sel_valid, busy, done}); end
    // Valid bits really cleared: a new start finds nothing.
    do_start();
    checks++; if ({sel_valid, done} !== 2'b01) begin errors++; $display("FAIL clr_restart got %b exp 01", {sel_valid, done}); end
    sel_ready = 1'b0;
  endtask

  task automatic test_rst_mid_scan();
    for (int k = 0; k < 8; k++) wr(k, 16'h0080 << k);
    sel_ready = 1'b1;
    do_start();
    tick(); tick(); tick();
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL rst_presel got %0d exp 3", sel); end
    rst = 1'b1;
    #2;
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rst_async_sel got %0d exp 0", sel); end
    checks++; if ({sel_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_async_flags got %b exp 000", {sel_valid, busy, done}); end
    checks++; if (words !== 128'd0) begin errors++; $display("FAIL rst_async_words got %h exp 0", words); end
    tick();
    rst = 1'b0;
    sel_ready = 1'b0;
    tick();
  endtask

  task automatic test_clear_write_same_edge();
    do_clear();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hBEEF; clear = 1'b1;
    tick();
    wr_en = 1'b0; clear = 1'b0;
    checks++; if (words[6*16 +: 16] !== 16'hBEEF) begin errors++; $display("FAIL sameedge_data got %h exp beef", words[6*16 +: 16]); end
    do_start();
    checks++; if ({sel_valid, done} !== 2'b01) begin errors++; $display("FAIL sameedge_valid got %b exp 01", {sel_valid, done}); end
  endtask

`ifdef SCAN_WRAP_EN
  task automatic test_wrap();
    logic [2:0] exp_sel [4];
    logic       exp_done [4];
    exp_sel  = '{3'd1, 3'd6, 3'd1, 3'd6};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_clear();
    wr(1, 16'h0100);
    wr(6, 16'h2000);
    sel_ready = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      checks++; if (sel !== exp_sel[i]) begin errors++; $display("FAIL wrap_sel[%0d] got %0d exp %0d", i, sel, exp_sel[i]); end
      checks++; if ({busy, sel_valid, done} !== {2'b11, exp_done[i]}) begin errors++; $display("FAIL wrap_flags[%0d] got %b exp %b", i, {busy, sel_valid, done}, {2'b11, exp_done[i]}); end
      tick();
    end
    sel_ready = 1'b0;
    do_clear();
  endtask
`else
  task automatic test_full_scan();
    for (int k = 0; k < 8; k++) wr(k, 16'h0080 << k);
    checks++; if (words[7*16 +: 16] !== 16'h4000) begin errors++; $display("FAIL full_word7 got %h exp 4000", words[7*16 +: 16]); end
    sel_ready = 1'b1;
    do_start();
    for (int k = 0; k < 8; k++) begin
      checks++; if ({sel_valid, busy, sel} !== {2'b11, 3'(k)}) begin errors++; $display("FAIL full_sel[%0d] got %b exp %b", k, {sel_valid, busy, sel}, {2'b11, 3'(k)}); end
      checks++; if (words[16*sel +: 16] !== (16'h0080 << k)) begin errors++; $display("FAIL full_data[%0d] got %h exp %h", k, words[16*sel +: 16], 16'h0080 << k); end
      tick();
    end
    checks++; if ({sel_valid, busy, done, sel} !== {3'b001, 3'd7}) begin errors++; $display("FAIL full_end got %b exp 0011_11", {sel_valid, busy, done, sel}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got %b exp 0", done); end
    sel_ready = 1'b0;
  endtask

  task automatic test_sparse();
    logic [2:0]  exp_sel [3];
    logic [15:0] exp_dat [3];
    exp_sel = '{3'd2, 3'd5, 3'd7};
    exp_dat = '{16'h0200, 16'h1000, 16'h4000};
    do_clear();
    wr(2, 16'h0200); wr(5, 16'h1000); wr(7, 16'h4000);
    sel_ready = 1'b1;
    do_start();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({sel_valid, sel} !== {1'b1, exp_sel[i]}) begin errors++; $display("FAIL sparse_sel[%0d] got %b exp %b", i, {sel_valid, sel}, {1'b1, exp_sel[i]}); end
      checks++; if (words[16*sel +: 16] !== exp_dat[i]) begin errors++; $display("FAIL sparse_data[%0d] got %h exp %h", i, words[16*sel +: 16], exp_dat[i]); end
      tick();
    end
    checks++; if ({sel_valid, busy, done} !== 3'b001) begin errors++; $display("FAIL sparse_end got %b exp 001", {sel_valid, busy, done}); end
    sel_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    sel_ready = 1'b1;
    do_start();
    checks++; if (sel !== 3'd2) begin errors++; $display("FAIL bp_first got %0d exp 2", sel); end
    tick();
    sel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({sel_valid, sel} !== {1'b1, 3'd5}) begin errors++; $display("FAIL bp_hold[%0d] got %b exp 1101", i, {sel_valid, sel}); end
      tick();
    end
    sel_ready = 1'b1;
    checks++; if ({sel_valid, sel} !== {1'b1, 3'd5}) begin errors++; $display("FAIL bp_release got %b exp 1101", {sel_valid, sel}); end
    tick();
    checks++; if ({sel_valid, sel} !== {1'b1, 3'd7}) begin errors++; $display("FAIL bp_next got %b exp 1111", {sel_valid, sel}); end
    tick();
    checks++; if ({sel_valid, busy, done} !== 3'b001) begin errors++; $display("FAIL bp_end got %b exp 001", {sel_valid, busy, done}); end
    sel_ready = 1'b0;
    tick();
  endtask

  task automatic test_write_during_scan();
    do_clear();
    wr(1, 16'h0111);
    sel_ready = 1'b0;
    do_start();
    checks++; if ({sel_valid, sel} !== {1'b1, 3'd1}) begin errors++; $display("FAIL wds_first got %b exp 1001", {sel_valid, sel}); end
    wr(4, 16'h0444);
    wr(0, 16'h0000);
    sel_ready = 1'b1;
    tick();
    checks++; if ({sel_valid, sel} !== {1'b1, 3'd4}) begin errors++; $display("FAIL wds_above got %b exp 1100", {sel_valid, sel}); end
    tick();
    checks++; if ({sel_valid, busy, done} !== 3'b001) begin errors++; $display("FAIL wds_below_skipped got %b exp 001", {sel_valid, busy, done}); end
    sel_ready = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef SCAN_WRAP_EN
    test_wrap();
`else
    test_full_scan();
    test_sparse();
    test_backpressure();
    test_write_during_scan();
`endif
    test_empty();
    test_clear_write_same_edge();
    test_clear_mid_scan();
    test_rst_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
